// File: rtl/edge_scanner_pkg.sv
// ---------------------------------------------------------------------------
// edge_scanner_pkg
// Shared types and constants for the edge scanner:
//   state_t  - scan controller states
//   line_t   - which scan line a returned pixel belongs to (row or column)
//   FOUND_*  - bit positions inside the 4-bit found vector
// ---------------------------------------------------------------------------
package edge_scanner_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW   = 3'd1,
    COL   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic {
    LINE_ROW = 1'b0,
    LINE_COL = 1'b1
  } line_t;

  localparam int FOUND_LEFT  = 0;
  localparam int FOUND_RIGHT = 1;
  localparam int FOUND_TOP   = 2;
  localparam int FOUND_BOT   = 3;

endpackage

// File: rtl/edge_scanner_run_matcher.sv
// ---------------------------------------------------------------------------
// run_matcher
// Streaming detector for a step pattern of RUN pixels on each side.
// Keeps the recent pixel history of the current line plus a saturating fill
// counter; matches are only reported once 2*RUN pixels of the line exist.
//
// Ports
//   clk_in     system clock
//   rst_n_in   asynchronous active-low reset
//   clear_in   synchronous clear of history and fill count
//   valid_in   pixel_in carries a pixel this cycle
//   first_in   this pixel is the first of a new line (history restarts)
//   pixel_in   thresholded pixel
//   rise_out   last 2*RUN pixels are RUN zeros followed by RUN ones
//   fall_out   last 2*RUN pixels are RUN ones followed by RUN zeros
// ---------------------------------------------------------------------------
module run_matcher #(
  parameter int RUN = 8
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear_in,
  input  logic valid_in,
  input  logic first_in,
  input  logic pixel_in,
  output logic rise_out,
  output logic fall_out
);

  localparam int HW = 2 * RUN;
  localparam int CW = $clog2(HW + 1);

  // Older pixels sit in higher bits, the newest pixel is bit 0 of the window.
  localparam logic [HW-1:0] RISE_PAT = {{RUN{1'b0}}, {RUN{1'b1}}};
  localparam logic [HW-1:0] FALL_PAT = ~RISE_PAT;

  // Together with the incoming pixel the stored 2*RUN-1 bits form the full
  // 2*RUN-pixel history the comparators look at.
  logic [HW-2:0] hist_reg;
  logic [CW-1:0] fill_reg;

  logic [HW-2:0] hist_eff;
  logic [CW-1:0] fill_eff;
  logic [HW-1:0] window;
  logic          full;

  // The first pixel of a line sees an empty history so the previous line
  // never leaks into the new one, without needing a separate clear cycle.
  always_comb begin
    hist_eff = first_in ? '0 : hist_reg;
    fill_eff = first_in ? '0 : fill_reg;
    window   = {hist_eff, pixel_in};
    full     = (fill_eff >= CW'(HW - 1));
    rise_out = valid_in && full && (window == RISE_PAT);
    fall_out = valid_in && full && (window == FALL_PAT);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (clear_in) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (valid_in) begin
      hist_reg <= window[HW-2:0];
      fill_reg <= (fill_eff == CW'(HW)) ? fill_eff : fill_eff + CW'(1);
    end
  end

endmodule

// File: rtl/edge_scanner.sv
// ---------------------------------------------------------------------------
// edge_scanner
// Scans one image row and one image column through a thresholded frame
// buffer and reports the first rising and last falling RUN-pixel step on
// each line as left/right (row) and top/bottom (column) edges.
//
// Parameters
//   WIDTH, HEIGHT   image size in pixels
//   RUN             half-pattern length in pixels
//   READ_LATENCY    frame-buffer read latency in cycles (1..4)
//
// Ports
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   start_in        start request, honoured only while idle
//   x_center_in     column to scan / row position of the row scan
//   y_center_in     row to scan / column position of the column scan
//   rd_en_out       frame-buffer read strobe
//   addr_out        frame-buffer address (y*WIDTH + x)
//   pixel_in        pixel returned READ_LATENCY cycles after rd_en_out
//   busy_out        scan in progress
//   done_out        one-cycle completion pulse
//   left/right_edge_out, top/bot_edge_out   detected edges
//   found_out       per-edge valid {bot, top, right, left}
// ---------------------------------------------------------------------------
module edge_scanner
  import edge_scanner_pkg::*;
#(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int RUN          = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic [$clog2(WIDTH)-1:0]          x_center_in,
  input  logic [$clog2(HEIGHT)-1:0]         y_center_in,
  output logic                              rd_en_out,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
  input  logic                              pixel_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [$clog2(WIDTH)-1:0]          left_edge_out,
  output logic [$clog2(WIDTH)-1:0]          right_edge_out,
  output logic [$clog2(HEIGHT)-1:0]         top_edge_out,
  output logic [$clog2(HEIGHT)-1:0]         bot_edge_out,
  output logic [3:0]                        found_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int IW = (XW > YW) ? XW : YW;

  // Tag travelling alongside each outstanding read so the returned pixel
  // can be attributed to its line and position without buffering the line.
  typedef struct packed {
    logic          valid;
    line_t         line;
    logic [IW-1:0] idx;
  } tag_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_c_reg;
  logic [YW-1:0] y_c_reg;
  logic [IW-1:0] cnt_reg;
  logic [2:0]    drain_reg;

  logic          rd_en;
  logic          busy;
  logic          done;
  line_t         line_cur;
  logic [AW-1:0] rd_addr;

  logic          x_bad;
  logic          y_bad;
  logic          start_accept;

  tag_t [READ_LATENCY-1:0] pipe_reg;
  tag_t                    tag_now;
  tag_t                    tail;

  logic          rise_match;
  logic          fall_match;

  logic [XW-1:0] left_reg, right_reg;
  logic [YW-1:0] top_reg, bot_reg;
  logic [3:0]    found_reg;

  // Centre range checks only exist when the port can encode values past
  // the image edge; for power-of-two sizes every code is in range.
  if ((2 ** XW) > WIDTH) begin : g_xchk
    assign x_bad = (x_center_in >= XW'(WIDTH));
  end else begin : g_xnochk
    assign x_bad = 1'b0;
  end

  if ((2 ** YW) > HEIGHT) begin : g_ychk
    assign y_bad = (y_center_in >= YW'(HEIGHT));
  end else begin : g_ynochk
    assign y_bad = 1'b0;
  end

  assign start_accept = (state_reg == IDLE) && start_in;

  // -------------------------------------------------------------------------
  // Controller: next state and decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    line_cur   = LINE_ROW;
    rd_addr    = '0;
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          state_next = (x_bad || y_bad) ? DONE : ROW;
        end
      end
      ROW: begin
        rd_en    = 1'b1;
        busy     = 1'b1;
        line_cur = LINE_ROW;
        rd_addr  = AW'(y_c_reg) * AW'(WIDTH) + AW'(cnt_reg);
        if (cnt_reg == IW'(WIDTH - 1)) begin
          state_next = COL;
        end
      end
      COL: begin
        rd_en    = 1'b1;
        busy     = 1'b1;
        line_cur = LINE_COL;
        rd_addr  = AW'(cnt_reg) * AW'(WIDTH) + AW'(x_c_reg);
        if (cnt_reg == IW'(HEIGHT - 1)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Waits for the last column pixel still in flight in the buffer.
        if (drain_reg == 3'(READ_LATENCY - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      x_c_reg   <= '0;
      y_c_reg   <= '0;
      cnt_reg   <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start_in) begin
            x_c_reg   <= x_center_in;
            y_c_reg   <= y_center_in;
            cnt_reg   <= '0;
            drain_reg <= '0;
          end
        end
        ROW: begin
          cnt_reg <= (cnt_reg == IW'(WIDTH - 1)) ? '0 : cnt_reg + IW'(1);
        end
        COL: begin
          cnt_reg <= (cnt_reg == IW'(HEIGHT - 1)) ? '0 : cnt_reg + IW'(1);
        end
        DRAIN: begin
          drain_reg <= drain_reg + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read tag pipeline: stage READ_LATENCY-1 lines up with pixel_in
  // -------------------------------------------------------------------------
  always_comb begin
    tag_now       = '0;
    tag_now.valid = rd_en;
    tag_now.line  = line_cur;
    tag_now.idx   = cnt_reg;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pipe_reg <= '0;
    end else begin
      pipe_reg[0] <= tag_now;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_reg[k] <= pipe_reg[k-1];
      end
    end
  end

  assign tail = pipe_reg[READ_LATENCY-1];

  run_matcher #(
    .RUN(RUN)
  ) u_matcher (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear_in (start_accept),
    .valid_in (tail.valid),
    .first_in (tail.valid && (tail.idx == '0)),
    .pixel_in (pixel_in),
    .rise_out (rise_match),
    .fall_out (fall_match)
  );

  // -------------------------------------------------------------------------
  // Edge registers. A match implies idx >= 2*RUN-1, so the subtractions
  // below cannot wrap. Rising edges keep the first hit, falling the last.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      left_reg  <= '0;
      right_reg <= '0;
      top_reg   <= '0;
      bot_reg   <= '0;
      found_reg <= '0;
    end else if (start_accept) begin
      left_reg  <= '0;
      right_reg <= '0;
      top_reg   <= '0;
      bot_reg   <= '0;
      found_reg <= '0;
    end else if (tail.valid) begin
      if (rise_match) begin
        if (tail.line == LINE_ROW && !found_reg[FOUND_LEFT]) begin
          left_reg              <= XW'(tail.idx - IW'(RUN - 1));
          found_reg[FOUND_LEFT] <= 1'b1;
        end
        if (tail.line == LINE_COL && !found_reg[FOUND_TOP]) begin
          top_reg              <= YW'(tail.idx - IW'(RUN - 1));
          found_reg[FOUND_TOP] <= 1'b1;
        end
      end
      if (fall_match) begin
        if (tail.line == LINE_ROW) begin
          right_reg              <= XW'(tail.idx - IW'(RUN));
          found_reg[FOUND_RIGHT] <= 1'b1;
        end else begin
          bot_reg              <= YW'(tail.idx - IW'(RUN));
          found_reg[FOUND_BOT] <= 1'b1;
        end
      end
    end
  end

  assign rd_en_out      = rd_en;
  assign addr_out       = rd_addr;
  assign busy_out       = busy;
  assign done_out       = done;
  assign left_edge_out  = left_reg;
  assign right_edge_out = right_reg;
  assign top_edge_out   = top_reg;
  assign bot_edge_out   = bot_reg;
  assign found_out      = found_reg;

endmodule

// File: tb/tb_edge_scanner.sv
// ---------------------------------------------------------------------------
// tb_edge_scanner
// Directed bench for edge_scanner at WIDTH=32, HEIGHT=24, RUN=4,
// READ_LATENCY=2. A behavioural frame buffer answers reads; expected
// addresses and edge results are queued when a scan is started and popped
// when the DUT issues reads or pulses done_out.
// ---------------------------------------------------------------------------
module tb_edge_scanner;

  localparam int W   = 32;
  localparam int H   = 24;
  localparam int RUN = 4;
  localparam int RL  = 2;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int AW  = $clog2(W * H);

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          start_in = 1'b0;
  logic [XW-1:0] x_center_in = '0;
  logic [YW-1:0] y_center_in = '0;
  logic          rd_en_out;
  logic [AW-1:0] addr_out;
  logic          pixel_in;
  logic          busy_out;
  logic          done_out;
  logic [XW-1:0] left_edge_out;
  logic [XW-1:0] right_edge_out;
  logic [YW-1:0] top_edge_out;
  logic [YW-1:0] bot_edge_out;
  logic [3:0]    found_out;

  always #5 clk_in = ~clk_in;

  edge_scanner #(
    .WIDTH(W), .HEIGHT(H), .RUN(RUN), .READ_LATENCY(RL)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_in       (start_in),
    .x_center_in    (x_center_in),
    .y_center_in    (y_center_in),
    .rd_en_out      (rd_en_out),
    .addr_out       (addr_out),
    .pixel_in       (pixel_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .left_edge_out  (left_edge_out),
    .right_edge_out (right_edge_out),
    .top_edge_out   (top_edge_out),
    .bot_edge_out   (bot_edge_out),
    .found_out      (found_out)
  );

  // Frame buffer model: RL-cycle registered read path.
  logic img [0:W*H-1];
  logic mem_pipe [0:RL-1];

  always @(posedge clk_in) begin
    mem_pipe[0] <= rd_en_out ? img[addr_out] : 1'b0;
    for (int k = 1; k < RL; k++) mem_pipe[k] <= mem_pipe[k-1];
  end
  assign pixel_in = mem_pipe[RL-1];

  typedef struct {
    int left;
    int right;
    int top;
    int bot;
    int found;
  } result_t;

  result_t exp_q[$];
  int      addr_q[$];
  int      checks = 0;
  int      errors = 0;
  int      exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Address scoreboard: every read must match the next queued address.
  always @(negedge clk_in) begin
    if (rst_n_in && rd_en_out) begin
      if (addr_q.size() == 0) begin
        checks++;
        assert (addr_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_read: observed read of %0d expected no read", addr_out);
        end
      end else begin
        exp_addr = addr_q.pop_front();
        check("read_addr", 32'(addr_out), exp_addr);
      end
    end
  end

  task automatic clear_img();
    for (int i = 0; i < W * H; i++) img[i] = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) img[y * W + x] = 1'b1;
  endtask

  task automatic push_addrs(input int xc, input int yc);
    for (int x = 0; x < W; x++) addr_q.push_back(yc * W + x);
    for (int y = 0; y < H; y++) addr_q.push_back(y * W + xc);
  endtask

  task automatic check_result(input string pfx, input result_t e);
    check({pfx, "_left"},  32'(left_edge_out),  e.left);
    check({pfx, "_right"}, 32'(right_edge_out), e.right);
    check({pfx, "_top"},   32'(top_edge_out),   e.top);
    check({pfx, "_bot"},   32'(bot_edge_out),   e.bot);
    check({pfx, "_found"}, 32'(found_out),      e.found);
  endtask

  // Start a scan, optionally re-pulse start at cycles 10 and 40, and check
  // the done cycle, single pulse, results and that every read was consumed.
  // Cycle 0 is the clock in which start_in is sampled.
  task automatic run_scan(input string name, input int xc, input int yc,
                          input bit repulse, input int exp_done, input result_t e);
    int      done_at;
    int      ndone;
    result_t got;
    done_at = -1;
    ndone   = 0;
    @(negedge clk_in);
    x_center_in = XW'(xc);
    y_center_in = YW'(yc);
    start_in    = 1'b1;
    exp_q.push_back(e);
    if (xc < W && yc < H) push_addrs(xc, yc);
    @(posedge clk_in);
    #1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk_in);
        #1;
      end
      start_in = repulse && (cyc == 10 || cyc == 40);
      if (done_out === 1'b1) begin
        ndone++;
        if (done_at < 0) begin
          done_at = cyc;
          got = exp_q.pop_front();
          check_result(name, got);
          check({name, "_busy_at_done"}, 32'(busy_out), 0);
        end
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    start_in = 1'b0;
    if (done_at < 0) exp_q.delete();
    check({name, "_done_cycle"}, done_at, exp_done);
    check({name, "_done_pulses"}, ndone, 1);
    check({name, "_reads_left"}, addr_q.size(), 0);
    check({name, "_hold_found"}, 32'(found_out), e.found);
    check({name, "_hold_left"}, 32'(left_edge_out), e.left);
    $display("scan %s centre=(%0d,%0d) done_cycle=%0d edges L%0d R%0d T%0d B%0d found=%b",
             name, xc, yc, done_at, left_edge_out, right_edge_out,
             top_edge_out, bot_edge_out, found_out);
    addr_q.delete();
  endtask

  initial begin
    int ndone;

    // Reset state
    #2;
    check("rst_busy",  32'(busy_out),  0);
    check("rst_done",  32'(done_out),  0);
    check("rst_rd_en", 32'(rd_en_out), 0);
    check("rst_found", 32'(found_out), 0);
    check("rst_left",  32'(left_edge_out), 0);
    check("rst_addr",  32'(addr_out),  0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    $display("reset released");

    // Ones rectangle x 8..19, y 5..14
    clear_img();
    set_rect(8, 19, 5, 14);
    run_scan("rect", 12, 10, 1'b0, 59, '{8, 19, 5, 14, 15});

    // Row centre past the image: no reads, done in cycle 1, results cleared.
    // (The column port cannot exceed the image at WIDTH=32.)
    run_scan("out_of_range", 12, 30, 1'b0, 1, '{0, 0, 0, 0, 0});

    // Extra start pulses during the scan are ignored
    run_scan("repulse", 12, 10, 1'b1, 59, '{8, 19, 5, 14, 15});

    // Row 10: ones at 2..9 (too close to the line start) and 16..25
    clear_img();
    set_rect(2, 9, 10, 10);
    set_rect(16, 25, 10, 10);
    run_scan("two_runs", 5, 10, 1'b0, 59, '{16, 25, 0, 0, 3});

    // All-zero image
    clear_img();
    run_scan("zeros", 12, 10, 1'b0, 59, '{0, 0, 0, 0, 0});

    // Reset in the middle of a scan
    set_rect(8, 19, 5, 14);
    @(negedge clk_in);
    x_center_in = XW'(12);
    y_center_in = YW'(10);
    start_in    = 1'b1;
    push_addrs(12, 10);
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (29) @(posedge clk_in);
    #1;
    check("mid_found_before_reset", 32'(found_out), 3);
    rst_n_in = 1'b0;
    #1;
    addr_q.delete();
    check("mid_rst_busy",  32'(busy_out),  0);
    check("mid_rst_rd_en", 32'(rd_en_out), 0);
    check("mid_rst_done",  32'(done_out),  0);
    check("mid_rst_found", 32'(found_out), 0);
    check("mid_rst_left",  32'(left_edge_out), 0);
    check("mid_rst_right", 32'(right_edge_out), 0);
    check("mid_rst_addr",  32'(addr_out),  0);
    $display("reset asserted mid-scan: busy=%0d found=%b", busy_out, found_out);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_in);
      #1;
      if (done_out === 1'b1) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    check("idle_after_reset", 32'(busy_out), 0);
    run_scan("after_reset", 12, 10, 1'b0, 59, '{8, 19, 5, 14, 15});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
